// File: rtl/resp_router_pkg.sv
// Shared MemNet response constants: base message width and the helpers that
// locate the opaque field and destination ID at the top of a message.
package MemNetRespPkg;

    localparam int c_resp_base_bits = 39;

    function automatic int id_bits(input int num_dst);
        return (num_dst > 1) ? $clog2(num_dst) : 1;
    endfunction

    function automatic int opaq_lsb(input int msg_bits, input int opaq_bits);
        return msg_bits - opaq_bits;
    endfunction

    // The destination ID is the most significant slice of the opaque field.
    function automatic int id_lsb(input int msg_bits, input int num_dst);
        return msg_bits - id_bits(num_dst);
    endfunction

endpackage

// File: rtl/resp_router_fifo.sv
// Two-entry circular FIFO owned by one destination port; the head entry drives
// the output directly, and a full FIFO accepts when the head leaves the same cycle.
module RespRouterFifo #(
    parameter int p_msg_bits = 47
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enq_val,
    output logic                  o_enq_rdy,
    input  logic [p_msg_bits-1:0] i_enq_msg,
    output logic                  o_deq_val,
    input  logic                  i_deq_rdy,
    output logic [p_msg_bits-1:0] o_deq_msg
);

    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;
    logic [p_msg_bits-1:0] r_mem [2];

    logic w_enq;
    logic w_deq;

    assign o_deq_val = (r_count != 2'd0);
    assign o_deq_msg = r_mem[r_rd_ptr];
    assign o_enq_rdy = (r_count != 2'd2) | i_deq_rdy;
    assign w_enq     = i_enq_val & o_enq_rdy;
    assign w_deq     = o_deq_val & i_deq_rdy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_enq) r_wr_ptr <= ~r_wr_ptr;
            if (w_deq) r_rd_ptr <= ~r_rd_ptr;
            if (w_enq && !w_deq)      r_count <= r_count + 2'd1;
            else if (w_deq && !w_enq) r_count <= r_count - 2'd1;
        end
    end

    // NOTE: storage has no reset; the count/pointers alone decide validity,
    // so stale data is never visible and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= i_enq_msg;
    end

endmodule

// File: rtl/resp_router.sv
// Routes memory responses to per-requester ports by the destination ID held in
// the opaque field; one input register feeds a 2-entry FIFO per destination.
module resp_router
    import MemNetRespPkg::*;
#(
    parameter int p_num_dst   = 3,
    parameter int p_opaq_bits = 8,   // must be >= clog2(p_num_dst)
    parameter int p_msg_bits  = c_resp_base_bits + p_opaq_bits
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 resp_val,
    output logic                                 resp_rdy,
    input  logic [p_msg_bits-1:0]                resp_msg,
    output logic [p_num_dst-1:0]                 dst_val,
    input  logic [p_num_dst-1:0]                 dst_rdy,
    output logic [p_num_dst-1:0][p_msg_bits-1:0] dst_msg,
    output logic                                 err_bad_dst
);

    localparam int c_id_bits = id_bits(p_num_dst);
    localparam int c_id_lsb  = id_lsb(p_msg_bits, p_num_dst);

    logic                  r_in_val;
    logic [p_msg_bits-1:0] r_in_msg;
    logic [c_id_bits-1:0]  r_in_id;
    logic                  r_err_bad_dst;

    logic                  w_resp_xfer;
    logic                  w_id_bad;
    logic                  w_tgt_rdy;
    logic                  w_in_drain;
    logic [p_num_dst-1:0]  w_enq_val;
    logic [p_num_dst-1:0]  w_enq_rdy;

    assign w_id_bad    = int'(r_in_id) >= p_num_dst;
    assign w_in_drain  = r_in_val & (w_id_bad | w_tgt_rdy);
    assign resp_rdy    = ~r_in_val | w_in_drain;
    assign w_resp_xfer = resp_val & resp_rdy;
    assign err_bad_dst = r_err_bad_dst;

    // NOTE: give every always_comb output a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_tgt_rdy = 1'b0;
        for (int k = 0; k < p_num_dst; k++) begin
            if (r_in_id == c_id_bits'(k)) w_tgt_rdy = w_enq_rdy[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_val      <= 1'b0;
            r_err_bad_dst <= 1'b0;
        end else begin
            if (w_resp_xfer)     r_in_val <= 1'b1;
            else if (w_in_drain) r_in_val <= 1'b0;
            if (r_in_val && w_id_bad) r_err_bad_dst <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_resp_xfer) begin
            r_in_msg <= resp_msg;
            r_in_id  <= resp_msg[c_id_lsb +: c_id_bits];
        end
    end

    for (genvar k = 0; k < p_num_dst; k++) begin : g_dst
        assign w_enq_val[k] = r_in_val & (r_in_id == c_id_bits'(k));

        RespRouterFifo #(
            .p_msg_bits (p_msg_bits)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_enq_val (w_enq_val[k]),
            .o_enq_rdy (w_enq_rdy[k]),
            .i_enq_msg (r_in_msg),
            .o_deq_val (dst_val[k]),
            .i_deq_rdy (dst_rdy[k]),
            .o_deq_msg (dst_msg[k])
        );
    end

endmodule
